// File: rtl/apb_master.sv
// APB4 requester: one outstanding command/response turned into an APB transfer,
// with a programmable PREADY wait-state timeout.
module apb_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [2:0]            PPROT,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic                  PWAKEUP,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    output logic [2:0]            State
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    psel_q, penable_q, pwake_q, pwake_d;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [2:0]              pprot_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_WIDTH-1:0]   pstrb_q;
    logic                    rsp_valid_q, rsp_slverr_q, rsp_timeout_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    accept, complete, expire, done;

    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q && !PRESET;
    assign accept    = cmd_valid && cmd_ready;
    assign complete  = (state_q == ACCESS) && PREADY;
    // Terminal count reached with the completer still stalling.
    assign expire    = (TIMEOUT != 0) && (state_q == ACCESS) && !PREADY
                       && (cnt_q == CW'(TIMEOUT - 1));
    assign done      = complete || expire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pwake_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                pwake_d = cmd_valid;
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                pwake_d = 1'b1;
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                pwake_d = !done;
                if (done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwake_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            psel_q    <= (state_d != IDLE);
            penable_q <= (state_d == ACCESS);
            pwake_q   <= pwake_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pprot_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (accept) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pprot_q  <= cmd_prot;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
            pstrb_q  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (complete) begin
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                rsp_slverr_q  <= PSLVERR;
                rsp_timeout_q <= 1'b0;
            end else if (expire) begin
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= '0;
                rsp_slverr_q  <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign PADDR       = paddr_q;
    assign PPROT       = pprot_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PWAKEUP     = pwake_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;
    assign State       = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level reference model checked every
// cycle, plus directed transfers with hand-computed results.
module tb_apb_master;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int SW  = 1;
    localparam int TMO = 3;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr, rsp_timeout;
    logic [AW-1:0] PADDR;
    logic [2:0]    PPROT;
    logic          PSELx, PENABLE, PWRITE, PWAKEUP;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;
    logic [DW-1:0] PRDATA = '0;
    logic [2:0]    State;

    int n_chk = 0;
    int n_pass = 0;

    int            cfg_waits = 0;
    logic [DW-1:0] cfg_rdata = '0;
    logic          cfg_err = 1'b0;

    apb_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PWAKEUP(PWAKEUP), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PRDATA(PRDATA), .State(State)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(negedge PCLK);
        #1;
    endtask

    // Transaction-level model: m_acc = 0 in setup, n in the n-th access cycle.
    bit            m_init = 0;
    bit            m_busy = 0;
    int            m_acc = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [SW-1:0] m_strb = '0;
    logic [2:0]    m_prot = '0;
    logic          m_write = 0;
    logic          m_rv = 0, m_err = 0, m_to = 0, m_wake = 0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge PCLK) begin
        bit fin, acc_now;
        if (PRESET) begin
            m_init = 1; m_busy = 0; m_acc = 0;
            m_addr = '0; m_wdata = '0; m_strb = '0; m_prot = '0;
            m_write = 0; m_rv = 0; m_err = 0; m_to = 0;
            m_rdata = '0; m_wake = 0;
        end else begin
            fin = m_busy && m_acc > 0 && (PREADY || m_acc == TMO);
            acc_now = !m_busy && cmd_valid && !m_rv;
            m_wake = (!m_busy && cmd_valid) || (m_busy && m_acc == 0)
                     || (m_busy && m_acc > 0 && !fin);
            if (m_rv && rsp_ready) m_rv = 0;
            if (acc_now) begin
                m_busy = 1; m_acc = 0;
                m_addr = cmd_addr; m_prot = cmd_prot; m_write = cmd_write;
                m_wdata = cmd_write ? cmd_wdata : '0;
                m_strb = cmd_write ? cmd_strb : '0;
            end else if (m_busy && m_acc == 0) begin
                m_acc = 1;
            end else if (m_busy) begin
                if (PREADY) begin
                    m_busy = 0; m_rv = 1; m_to = 0; m_err = PSLVERR;
                    m_rdata = m_write ? '0 : PRDATA;
                end else if (fin) begin
                    m_busy = 0; m_rv = 1; m_to = 1; m_err = 1; m_rdata = '0;
                end else begin
                    m_acc++;
                end
            end
        end
    end

    // Completer: PREADY after cfg_waits wait states; junk on data when not ready.
    always @(negedge PCLK) begin
        #1;
        PREADY  = m_busy && m_acc > 0 && (m_acc - 1) >= cfg_waits;
        PRDATA  = PREADY ? cfg_rdata : ~cfg_rdata;
        PSLVERR = PREADY ? cfg_err : !cfg_err;
    end

    always @(negedge PCLK) begin
        if (m_init) begin
            chk("state", State,
                !m_busy ? 3'b001 : (m_acc == 0 ? 3'b010 : 3'b100));
            chk("psel", PSELx, m_busy);
            chk("penable", PENABLE, m_busy && m_acc > 0);
            chk("pwakeup", PWAKEUP, m_wake);
            chk("bus", {PADDR, PPROT, PWRITE, PWDATA, PSTRB},
                {m_addr, m_prot, m_write, m_wdata, m_strb});
            chk("rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout},
                {m_rv, m_rdata, m_err, m_to});
            chk("cmd_ready", cmd_ready, !m_busy && !m_rv && !PRESET);
        end
    end

    task automatic run_txn(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [SW-1:0] s,
                           input logic [2:0] p, input int waits,
                           input logic [DW-1:0] prd, input logic perr,
                           input int exp_lat, input int exp_pen,
                           input logic [DW-1:0] exp_rd, input logic exp_err,
                           input logic exp_to);
        int n, lat, pen;
        cfg_waits = waits; cfg_rdata = prd; cfg_err = perr;
        cmd_write = w; cmd_addr = a; cmd_wdata = wd;
        cmd_strb = s; cmd_prot = p; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step(); n++;
        end
        chk("accept", cmd_ready, 1);
        step();
        cmd_valid = 0;
        lat = 1; pen = 0;
        while (!rsp_valid && lat < 40) begin
            if (PENABLE) pen++;
            chk("pwdata_hold", PWDATA, w ? wd : '0);
            chk("pstrb_hold", PSTRB, w ? s : '0);
            step(); lat++;
        end
        chk("latency", lat, exp_lat);
        chk("penable_cycles", pen, exp_pen);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_slverr", rsp_slverr, exp_err);
        chk("rsp_timeout", rsp_timeout, exp_to);
    endtask

    initial begin
        int n;
        PRESET = 1;
        step(); step();
        chk("rst_state", State, 3'b001);
        chk("rst_psel", PSELx, 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_ready", cmd_ready, 0);
        PRESET = 0;
        step();
        chk("post_rst_ready", cmd_ready, 1);

        run_txn(1, 8'h12, 8'hA5, 1'b1, 3'b000, 0, 8'h00, 0, 3, 1, 8'h00, 0, 0);
        step(); step();
        run_txn(0, 8'h34, 8'hFF, 1'b1, 3'b001, 2, 8'h3C, 0, 5, 3, 8'h3C, 0, 0);
        step();
        run_txn(1, 8'h80, 8'h11, 1'b1, 3'b100, 0, 8'h00, 1, 3, 1, 8'h00, 1, 0);
        step();
        run_txn(0, 8'h44, 8'h00, 1'b0, 3'b010, 99, 8'h99, 0, 5, 3, 8'h00, 1, 1);
        chk("tmo_psel_low", PSELx, 0);
        step();
        run_txn(0, 8'h45, 8'h00, 1'b0, 3'b011, 2, 8'h5A, 0, 5, 3, 8'h5A, 0, 0);
        step();

        rsp_ready = 0;
        run_txn(1, 8'h21, 8'h33, 1'b1, 3'b010, 0, 8'h00, 0, 3, 1, 8'h00, 0, 0);
        cmd_write = 0; cmd_addr = 8'h22; cmd_valid = 1;
        cfg_waits = 0; cfg_rdata = 8'hC3; cfg_err = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", cmd_ready, 0);
            chk("bp_state", State, 3'b001);
            chk("bp_rv", rsp_valid, 1);
            step();
        end
        rsp_ready = 1;
        chk("bp_ready_last", cmd_ready, 0);
        step();
        chk("bp_rv_clear", rsp_valid, 0);
        chk("bp_ready_up", cmd_ready, 1);
        chk("bp_still_idle", State, 3'b001);
        step();
        cmd_valid = 0;
        chk("bp_setup", State, 3'b010);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step(); n++;
        end
        chk("bp_rsp_steps", n, 2);
        chk("bp_rdata", rsp_rdata, 8'hC3);
        step();

        cfg_waits = 99;
        cmd_write = 0; cmd_addr = 8'h66; cmd_prot = 3'b001; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step(); n++;
        end
        step();
        cmd_valid = 0;
        step();
        chk("mid_access", State, 3'b100);
        PRESET = 1;
        step();
        chk("mid_rst_state", State, 3'b001);
        chk("mid_rst_bus", {PSELx, PENABLE, PWAKEUP, PADDR, PPROT}, '0);
        chk("mid_rst_rv", rsp_valid, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        PRESET = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_rsp", rsp_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester stage that converts a single-outstanding command/response handshake into APB4 transfers. It drives the PADDR/PPROT/PSELx/PENABLE/PWRITE/PWDATA/PSTRB/PWAKEUP bus consumed by the APB completer and the protocol checker, and exports its one-hot `State` so the checker can bind to it. It adds a programmable PREADY wait-state timeout so a hung completer cannot lock up the requester.

## Interface
Parameters:
- DATA_WIDTH, 8, PWDATA/PRDATA width (multiple of 8)
- ADDR_WIDTH, 8, PADDR width
- STRB_WIDTH, DATA_WIDTH/8, PSTRB width
- TIMEOUT, 16, max ACCESS wait states before abort; 0 disables the timeout

Ports:
- PCLK  in  1  single clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; = State==IDLE && !rsp_valid && !PRESET (combinational)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  write strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_slverr  out  1  PSLVERR captured, or 1 on timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR, PPROT(3), PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP  out  APB requester outputs, all registered
- PREADY, PSLVERR (1), PRDATA (DATA_WIDTH)  in  APB completer returns
- State  out  3  one-hot FSM state: IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100

## Operation
- FSM: IDLE -> SETUP on cmd_valid && cmd_ready. SETUP -> ACCESS unconditionally. ACCESS -> IDLE on PREADY or on timeout. ACCESS -> ACCESS otherwise. No ACCESS -> SETUP back-to-back path; every transfer returns to IDLE.
- Acceptance registers cmd_* onto PADDR/PPROT/PWRITE/PWDATA/PSTRB. For reads, PWDATA=0 and PSTRB=0.
- These outputs stay stable from SETUP through the last ACCESS cycle and hold their values in IDLE. Only PSELx, PENABLE and PWAKEUP deassert.
- PSELx=1 in SETUP and ACCESS. PENABLE=1 only in ACCESS.
- Completion (ACCESS && PREADY):
  - Load rsp_rdata = PWRITE ? 0 : PRDATA.
  - Load rsp_slverr = PSLVERR, rsp_timeout = 0.
  - Set rsp_valid.
  - PSLVERR and PRDATA are ignored when PREADY=0.
- Timeout:
  - Wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When PREADY=0 and the count equals TIMEOUT-1, abort: go to IDLE with rsp_valid=1, rsp_timeout=1, rsp_slverr=1, rsp_rdata=0.
  - PREADY=1 in the terminal-count cycle is a normal completion.
  - Counter width is $clog2(TIMEOUT+1).
- Response slot: a single entry, cleared on rsp_valid && rsp_ready. A new command is accepted only once the slot is empty, so a completion never overwrites a pending response.
- PWAKEUP next-value = (State==IDLE && cmd_valid) || State==SETUP || (State==ACCESS && !done). It therefore asserts with or before PSELx and drops with it.

## Timing
- Reset (PRESET high at an edge): on the following cycle State=IDLE; PSELx, PENABLE, PWAKEUP, PWRITE, PADDR, PPROT, PWDATA, PSTRB = 0; rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout = 0; wait counter = 0; cmd_ready=0 while PRESET is high.
- Reset mid-transfer aborts immediately: the bus drops next cycle, no response is produced, and any pending response is discarded.
- Accept at edge T: SETUP during T+1, ACCESS during T+2. With zero wait states, PREADY is sampled at the end of T+2 and State=IDLE with rsp_valid=1 during T+3.
- Minimum command-to-response latency is 3 cycles; each wait state adds 1.
- Minimum issue interval is 4 cycles when rsp_ready is held high: rsp_valid clears at edge T+3, so cmd_ready rises during T+4.
- rsp_ready high in the same cycle rsp_valid rises consumes the response at the next edge.

## Test plan
- Write: addr 0x12, wdata 0xA5, strb 1, PREADY tied 1 -> SETUP/ACCESS one cycle each, PWDATA=0xA5 stable across both; rsp_valid 3 cycles after accept with slverr=0, rdata=0.
- Read with 2 wait states: PRDATA=0x3C returned with PREADY -> PENABLE high for 3 cycles, PSTRB=0, rsp_rdata=0x3C, latency 5.
- Error: addr 0x80, slave returns PSLVERR=1 with PREADY -> rsp_slverr=1, rsp_timeout=0.
- Timeout: TIMEOUT=3, PREADY stuck 0 -> abort after the 3rd ACCESS cycle; rsp_timeout=1, rsp_slverr=1, PSELx=0 next cycle. Repeat with PREADY=1 in the 3rd cycle -> normal completion.
- Back-pressure: rsp_ready=0 for 5 cycles after completion, cmd_valid held -> cmd_ready stays 0 and no SETUP occurs until the cycle after rsp_ready=1.
- PRESET asserted during ACCESS -> IDLE, all outputs 0 next cycle, no rsp_valid.
